// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: state encoding, instruction
// field positions, operand select codes and jump condition codes.
package ctrl_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXECUTE = 2'd2,
    ST_STORE   = 2'd3
  } state_t;

  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned TYPE_BIT   = 15;
  localparam int unsigned IMM_HI     = 14;
  localparam int unsigned DEST_A_BIT = 14;
  localparam int unsigned DEST_D_BIT = 13;
  localparam int unsigned DEST_M_BIT = 12;
  localparam int unsigned YSEL_HI    = 11;
  localparam int unsigned YSEL_LO    = 10;
  localparam int unsigned XSEL_HI    = 9;
  localparam int unsigned XSEL_LO    = 8;
  localparam int unsigned ZX_BIT     = 7;
  localparam int unsigned ZY_BIT     = 6;
  localparam int unsigned NO_BIT     = 5;
  localparam int unsigned OP_HI      = 4;
  localparam int unsigned OP_LO      = 3;
  localparam int unsigned JMP_HI     = 2;
  localparam int unsigned JMP_LO     = 0;

  typedef enum logic [1:0] {
    SEL_A   = 2'd0,
    SEL_D   = 2'd1,
    SEL_M   = 2'd2,
    SEL_ONE = 2'd3
  } sel_t;

  typedef enum logic [2:0] {
    JMP_NEVER        = 3'd0,
    JMP_NOT_NEG      = 3'd1,
    JMP_ZERO         = 3'd2,
    JMP_NOT_NEG_ZERO = 3'd3,
    JMP_NEG          = 3'd4,
    JMP_NOT_ZERO     = 3'd5,
    JMP_NEG_ZERO     = 3'd6,
    JMP_ALWAYS       = 3'd7
  } jump_t;

endpackage

// File: rtl/jump_eval.sv
// Combinational jump decision from a condition code and the ALU flags.
module jump_eval
  import ctrl_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       neg,
  input  logic       zero,
  output logic       taken
);

  // Map each condition code onto the flag combination it tests.
  always_comb begin
    taken = 1'b0;
    case (jump_t'(cond))
      JMP_NEVER:        taken = 1'b0;
      JMP_NOT_NEG:      taken = ~neg;
      JMP_ZERO:         taken = zero;
      JMP_NOT_NEG_ZERO: taken = ~neg | zero;
      JMP_NEG:          taken = neg;
      JMP_NOT_ZERO:     taken = ~zero;
      JMP_NEG_ZERO:     taken = neg | zero;
      JMP_ALWAYS:       taken = 1'b1;
      default:          taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC, fetches over a valid
// handshake, decodes A/C instructions and drives ALU controls and the
// register-file write strobes.
//
// state   | meaning
// FETCH   | request imem at pc, wait for imem_valid, latch the word
// DECODE  | latch operands and jump target; stall while M is pending
// EXECUTE | ALU controls active, capture result flags
// STORE   | write strobes and retire for one cycle, update pc
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned PC_W     = 15,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_req,
  input  logic              imem_valid,
  input  logic [15:0]       imem_data,
  input  logic [DATA_W-1:0] reg_a_in,
  input  logic [DATA_W-1:0] reg_d_in,
  input  logic [DATA_W-1:0] reg_m_in,
  input  logic              m_valid,
  input  logic              is_negative,
  input  logic              is_zero,
  output logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y,
  output logic [1:0]        opcode,
  output logic              zero_x,
  output logic              zero_y,
  output logic              negate_output,
  output logic [DATA_W-1:0] imm_out,
  output logic              a_src_imm,
  output logic              reg_a_en,
  output logic              reg_d_en,
  output logic              reg_m_en,
  output logic [PC_W-1:0]   pc,
  output logic              retire
);

  localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

  state_t              state_q, state_d;
  logic [INSTR_W-1:0]  instr_q;
  logic [DATA_W-1:0]   x_q, y_q, x_sel, y_sel;
  logic [PC_W-1:0]     pc_q, target_q, pc_next;
  logic                neg_q, zero_q;
  logic                is_a, uses_m, m_wait, taken;
  logic                fetch_ld, opnd_ld, flag_ld, pc_ld;
  logic [1:0]          xsel, ysel;
  logic [2:0]          jmp;

  assign is_a   = instr_q[TYPE_BIT];
  assign xsel   = instr_q[XSEL_HI:XSEL_LO];
  assign ysel   = instr_q[YSEL_HI:YSEL_LO];
  assign jmp    = instr_q[JMP_HI:JMP_LO];
  // Only an M reference makes the data-memory read matter.
  assign uses_m = (xsel == SEL_M) || (ysel == SEL_M);
  assign m_wait = uses_m && !m_valid;

  jump_eval u_jump_eval (
    .cond  (jmp),
    .neg   (neg_q),
    .zero  (zero_q),
    .taken (taken)
  );

  // A-instructions always fall through; the target is A before writeback.
  assign pc_next = (!is_a && taken) ? target_q : pc_q + PC_W'(1);

  // Operand multiplexers for the x and y ALU inputs.
  always_comb begin
    x_sel = '0;
    y_sel = '0;
    case (sel_t'(xsel))
      SEL_A:   x_sel = reg_a_in;
      SEL_D:   x_sel = reg_d_in;
      SEL_M:   x_sel = reg_m_in;
      default: x_sel = DATA_W'(1);
    endcase
    case (sel_t'(ysel))
      SEL_A:   y_sel = reg_a_in;
      SEL_D:   y_sel = reg_d_in;
      SEL_M:   y_sel = reg_m_in;
      default: y_sel = DATA_W'(1);
    endcase
  end

  // Next-state logic and per-state load enables.
  always_comb begin
    state_d  = state_q;
    fetch_ld = 1'b0;
    opnd_ld  = 1'b0;
    flag_ld  = 1'b0;
    pc_ld    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (imem_valid) begin
          fetch_ld = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_a) begin
          state_d = ST_STORE;
        end else if (!m_wait) begin
          opnd_ld = 1'b1;
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        flag_ld = 1'b1;
        state_d = ST_STORE;
      end
      ST_STORE: begin
        pc_ld   = 1'b1;
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Output decode; everything is gated by state so a reset drops it at once.
  always_comb begin
    imem_req      = (state_q == ST_FETCH);
    opcode        = 2'b00;
    zero_x        = 1'b0;
    zero_y        = 1'b0;
    negate_output = 1'b0;
    reg_a_en      = 1'b0;
    reg_d_en      = 1'b0;
    reg_m_en      = 1'b0;
    a_src_imm     = 1'b0;
    retire        = 1'b0;
    if (state_q == ST_EXECUTE) begin
      opcode        = instr_q[OP_HI:OP_LO];
      zero_x        = instr_q[ZX_BIT];
      zero_y        = instr_q[ZY_BIT];
      negate_output = instr_q[NO_BIT];
    end
    if (state_q == ST_STORE) begin
      retire    = 1'b1;
      a_src_imm = is_a;
      reg_a_en  = is_a | instr_q[DEST_A_BIT];
      reg_d_en  = ~is_a & instr_q[DEST_D_BIT];
      reg_m_en  = ~is_a & instr_q[DEST_M_BIT];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction, operand, flag and PC registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      target_q <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      pc_q     <= RESET_PC_V;
    end else begin
      if (fetch_ld) instr_q <= imem_data;
      if (opnd_ld) begin
        x_q      <= x_sel;
        y_q      <= y_sel;
        target_q <= reg_a_in[PC_W-1:0];
      end
      if (flag_ld) begin
        neg_q  <= is_negative;
        zero_q <= is_zero;
      end
      if (pc_ld) pc_q <= pc_next;
    end
  end

  assign imm_out   = is_a ? DATA_W'(instr_q[IMM_HI:0]) : '0;
  assign x         = x_q;
  assign y         = y_q;
  assign pc        = pc_q;
  assign imem_addr = pc_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: a 16-bit and a 32-bit sequencer run in lockstep on shared
// stimulus; checks latency, strobes, operands and PC flow.
module tb_control_sequencer;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic [31:0] a_in, d_in, m_in;
  logic        m_valid, is_neg, is_zero;

  logic [14:0] addr16, pc16, addr32, pc32;
  logic        req16, zx16, zy16, no16, asrc16, ae16, de16, me16, ret16;
  logic        req32, zx32, zy32, no32, asrc32, ae32, de32, me32, ret32;
  logic [15:0] x16, y16, imm16;
  logic [31:0] x32, y32, imm32;
  logic [1:0]  op16, op32;

  int total = 0;
  int bad = 0;
  int cyc;
  int a_cnt, d_cnt, m_cnt, ret_cnt, alu_cnt;
  logic [4:0]  alu_seen;
  logic        asrc_ret;
  logic [15:0] imm_ret;
  logic [31:0] m_good, m_junk;

  always #5 clk = ~clk;

  control_sequencer #(.DATA_W(16), .PC_W(15), .RESET_PC(0)) dut16 (
    .clk(clk), .rst(rst), .imem_addr(addr16), .imem_req(req16),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .reg_a_in(a_in[15:0]), .reg_d_in(d_in[15:0]), .reg_m_in(m_in[15:0]),
    .m_valid(m_valid), .is_negative(is_neg), .is_zero(is_zero),
    .x(x16), .y(y16), .opcode(op16), .zero_x(zx16), .zero_y(zy16),
    .negate_output(no16), .imm_out(imm16), .a_src_imm(asrc16),
    .reg_a_en(ae16), .reg_d_en(de16), .reg_m_en(me16), .pc(pc16), .retire(ret16)
  );

  control_sequencer #(.DATA_W(32), .PC_W(15), .RESET_PC(0)) dut32 (
    .clk(clk), .rst(rst), .imem_addr(addr32), .imem_req(req32),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .reg_a_in(a_in), .reg_d_in(d_in), .reg_m_in(m_in),
    .m_valid(m_valid), .is_negative(is_neg), .is_zero(is_zero),
    .x(x32), .y(y32), .opcode(op32), .zero_x(zx32), .zero_y(zy32),
    .negate_output(no32), .imm_out(imm32), .a_src_imm(asrc32),
    .reg_a_en(ae32), .reg_d_en(de32), .reg_m_en(me32), .pc(pc32), .retire(ret32)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] cinstr(input logic [2:0] dest, input logic [1:0] ys,
                                         input logic [1:0] xs, input logic [2:0] fl,
                                         input logic [1:0] op, input logic [2:0] j);
    return {1'b0, dest, ys, xs, fl, op, j};
  endfunction

  task automatic clear_counts();
    a_cnt = 0; d_cnt = 0; m_cnt = 0; ret_cnt = 0; alu_cnt = 0;
    alu_seen = '0; asrc_ret = 1'b0; imm_ret = '0;
  endtask

  task automatic sample();
    if (ae16) a_cnt++;
    if (de16) d_cnt++;
    if (me16) m_cnt++;
    if (ret16) begin
      ret_cnt++;
      asrc_ret = asrc16;
      imm_ret  = imm16;
    end
    if ({op16, zx16, zy16, no16} != 5'b0) begin
      alu_cnt++;
      alu_seen = {op16, zx16, zy16, no16};
    end
  endtask

  // Fetch one instruction and run until retire; cyc counts from the
  // imem_valid cycle (1) through the retire cycle inclusive.
  task automatic run(input logic [15:0] instr, input int stall);
    int w;
    clear_counts();
    w = 0;
    while (!req16 && w < 20) begin
      tick();
      w++;
    end
    check("fetch_req", 32'(req16), 32'd1);
    imem_data  = instr;
    imem_valid = 1'b1;
    m_valid    = 1'b0;
    m_in       = m_junk;
    cyc = 1;
    sample();
    tick();
    imem_valid = 1'b0;
    imem_data  = 16'hFFFF;
    for (int k = 0; k < 30; k++) begin
      cyc++;
      sample();
      if (ret16) break;
      m_valid = (cyc >= 2 + stall);
      m_in    = m_valid ? m_good : m_junk;
      tick();
    end
    check("retire_seen", 32'(ret16), 32'd1);
  endtask

  initial begin
    rst = 1'b0; imem_valid = 1'b0; imem_data = '0;
    a_in = '0; d_in = '0; m_in = '0; m_valid = 1'b1; is_neg = 1'b0; is_zero = 1'b0;
    m_good = 32'h0BEE; m_junk = 32'hDEAD;
    clear_counts();
    tick(); tick();
    rst = 1'b1;
    #2;
    // reset state
    check("rst_pc", 32'(pc16), 32'd0);
    check("rst_addr", 32'(addr16), 32'd0);
    check("rst_req", 32'(req16), 32'd1);
    check("rst_xy", {x16, y16}, 32'd0);
    check("rst_strobes", 32'({ae16, de16, me16, asrc16, ret16}), 32'd0);
    check("rst_alu", 32'({op16, zx16, zy16, no16}), 32'd0);
    check("rst_imm", 32'(imm16), 32'd0);

    // A-instruction, immediate 0x1234
    run(16'h9234, 0);
    check("a_lat", 32'(cyc), 32'd3);
    check("a_imm", 32'(imm_ret), 32'h1234);
    check("a_en", 32'(a_cnt), 32'd1);
    check("a_src", 32'(asrc_ret), 32'd1);
    check("a_dm_en", 32'(d_cnt + m_cnt), 32'd0);
    check("a_alu", 32'(alu_cnt), 32'd0);
    tick();
    check("a_pc", 32'(pc16), 32'd1);
    check("a_ret_once", 32'(ret16), 32'd0);

    // C-instruction D = f(A, D), no jump
    a_in = 32'd5; d_in = 32'd7;
    run(cinstr(3'b010, 2'd1, 2'd0, 3'b101, 2'b10, 3'd0), 0);
    check("c_lat", 32'(cyc), 32'd4);
    check("c_x", 32'(x16), 32'd5);
    check("c_y", 32'(y16), 32'd7);
    check("c_d_en", 32'(d_cnt), 32'd1);
    check("c_am_en", 32'(a_cnt + m_cnt), 32'd0);
    check("c_asrc", 32'(asrc_ret), 32'd0);
    check("c_alu_cnt", 32'(alu_cnt), 32'd1);
    check("c_alu_val", 32'(alu_seen), 32'b10101);
    tick();
    check("c_pc", 32'(pc16), 32'd2);

    // unconditional jump to pre-write A, dest A, y = constant 1
    a_in = 32'h0040;
    run(cinstr(3'b100, 2'd3, 2'd0, 3'b000, 2'b00, 3'd7), 0);
    check("j7_y_one", 32'(y16), 32'd1);
    check("j7_a_en", 32'(a_cnt), 32'd1);
    check("j7_asrc", 32'(asrc_ret), 32'd0);
    tick();
    check("j7_pc", 32'(pc16), 32'h40);
    check("j7_pc32", 32'(pc32), 32'h40);

    // code 5 (~zero) with zero=1 -> not taken
    is_zero = 1'b1;
    run(cinstr(3'b010, 2'd1, 2'd3, 3'b000, 2'b01, 3'd5), 0);
    check("j5_x_one", 32'(x16), 32'd1);
    tick();
    check("j5_pc", 32'(pc16), 32'h41);

    // code 2 (zero) with zero=1 -> taken
    a_in = 32'h0010;
    run(cinstr(3'b000, 2'd0, 2'd0, 3'b000, 2'b00, 3'd2), 0);
    tick();
    check("j2_pc", 32'(pc16), 32'h10);

    // code 4 (neg) taken, then code 1 (~neg) not taken
    is_zero = 1'b0; is_neg = 1'b1; a_in = 32'h0020;
    run(cinstr(3'b000, 2'd0, 2'd0, 3'b000, 2'b00, 3'd4), 0);
    tick();
    check("j4_pc", 32'(pc16), 32'h20);
    a_in = 32'h0030;
    run(cinstr(3'b000, 2'd0, 2'd0, 3'b000, 2'b00, 3'd1), 0);
    tick();
    check("j1_pc", 32'(pc16), 32'h21);
    is_neg = 1'b0;

    // M operand stalls three DECODE cycles
    d_in = 32'd3;
    run(cinstr(3'b001, 2'd1, 2'd2, 3'b000, 2'b00, 3'd0), 3);
    check("m_lat", 32'(cyc), 32'd7);
    check("m_x", 32'(x16), 32'h0BEE);
    check("m_y", 32'(y16), 32'd3);
    check("m_en", 32'(m_cnt), 32'd1);
    check("m_ad_en", 32'(a_cnt + d_cnt), 32'd0);
    tick();
    check("m_pc", 32'(pc16), 32'h22);

    // m_valid low but M not referenced -> no stall
    run(cinstr(3'b010, 2'd1, 2'd0, 3'b000, 2'b00, 3'd0), 99);
    check("nom_lat", 32'(cyc), 32'd4);
    tick();
    check("nom_pc", 32'(pc16), 32'h23);
    m_valid = 1'b1;

    // PC wrap at 0x7FFF
    a_in = 32'h7FFF;
    run(cinstr(3'b000, 2'd0, 2'd0, 3'b000, 2'b00, 3'd7), 0);
    tick();
    check("wrap_pre", 32'(pc16), 32'h7FFF);
    run(cinstr(3'b000, 2'd0, 2'd0, 3'b000, 2'b00, 3'd0), 0);
    tick();
    check("wrap_pc", 32'(pc16), 32'd0);
    check("wrap_addr", 32'(addr16), 32'd0);
    check("wrap_pc32", 32'(pc32), 32'd0);

    // 32-bit datapath: jump target truncated to PC_W
    a_in = 32'h0001_0003;
    run(cinstr(3'b000, 2'd1, 2'd0, 3'b000, 2'b00, 3'd7), 0);
    check("w32_x", x32, 32'h0001_0003);
    check("w32_x16", 32'(x16), 32'h0003);
    tick();
    check("w32_pc", 32'(pc32), 32'd3);
    check("w16_pc", 32'(pc16), 32'd3);

    // reset asserted mid-EXECUTE
    a_in = 32'h0055;
    clear_counts();
    imem_data  = cinstr(3'b111, 2'd0, 2'd0, 3'b111, 2'b11, 3'd7);
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    tick();
    check("mid_exec_alu", 32'(op16), 32'd3);
    rst = 1'b0;
    #1;
    check("rst_mid_pc", 32'(pc16), 32'd0);
    check("rst_mid_strobes", 32'({ae16, de16, me16, ret16}), 32'd0);
    check("rst_mid_alu", 32'({op16, zx16, zy16, no16}), 32'd0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sample();
      tick();
    end
    check("post_rst_req", 32'(req16), 32'd1);
    check("post_rst_pc", 32'(pc16), 32'd0);
    check("post_rst_quiet", 32'(a_cnt + d_cnt + m_cnt + ret_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
